// File: rtl/reservation_station.sv
// reservation_station: DEPTH-entry station with ALU/memory tag wakeup and a registered ALU issue port.
// Define RS_OLDEST_FIRST_EN for age-based issue selection; otherwise the lowest-index ready entry issues.
module reservation_station #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [4:0]  op_in,
  input  logic [31:0] value1_in,
  input  logic [31:0] value2_in,
  input  logic [2:0]  query1_in,
  input  logic [2:0]  query2_in,
  input  logic [31:0] imm_in,
  input  logic [2:0]  target_in,
  input  logic [2:0]  alu_num,
  input  logic [31:0] alu_value,
  input  logic [2:0]  mem_num,
  input  logic [31:0] mem_value,
  input  logic        alu_ready,
  output logic        rs_full,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_imm,
  output logic [2:0]  alu_dest
);
  localparam logic [4:0] OP_NONE = 5'b11111;
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]  tag;
    logic [31:0] val;
  } operand_t;

  // ALU broadcast is checked first so it wins when both buses carry the same tag.
  function automatic operand_t resolve(input operand_t o,
                                       input logic [2:0] an, input logic [31:0] av,
                                       input logic [2:0] mn, input logic [31:0] mv);
    operand_t r;
    r = o;
    if (o.tag != 3'd0 && o.tag == an) begin
      r.tag = 3'd0;
      r.val = av;
    end else if (o.tag != 3'd0 && o.tag == mn) begin
      r.tag = 3'd0;
      r.val = mv;
    end
    return r;
  endfunction

  logic [DEPTH-1:0] valid_q, valid_d, ready;
  logic [4:0]       op_q   [DEPTH];
  logic [4:0]       op_d   [DEPTH];
  operand_t         src1_q [DEPTH];
  operand_t         src1_d [DEPTH];
  operand_t         src2_q [DEPTH];
  operand_t         src2_d [DEPTH];
  logic [31:0]      imm_q  [DEPTH];
  logic [31:0]      imm_d  [DEPTH];
  logic [2:0]       dest_q [DEPTH];
  logic [2:0]       dest_d [DEPTH];
`ifdef RS_OLDEST_FIRST_EN
  logic [2:0]       age_q  [DEPTH];
  logic [2:0]       age_d  [DEPTH];
  logic [2:0]       best_age;
`endif

  logic [4:0]  alu_op_q, alu_op_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_imm_q, alu_imm_d;
  logic [2:0]  alu_dest_q, alu_dest_d;

  logic             sel_found, free_found, issue, dispatch;
  logic [IDX_W-1:0] sel_idx, free_idx;

  assign rs_full  = &valid_q;
  assign issue    = alu_ready && sel_found;
  assign dispatch = (op_in != OP_NONE) && !rs_full && !flush;

  always_comb begin : select
    ready      = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
`ifdef RS_OLDEST_FIRST_EN
    best_age   = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = valid_q[i] && src1_q[i].tag == 3'd0 && src2_q[i].tag == 3'd0;
`ifdef RS_OLDEST_FIRST_EN
      if (ready[i] && (!sel_found || age_q[i] > best_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age_q[i];
      end
`else
      if (ready[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
`endif
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Free slot comes from registered valid bits, so an entry issuing this cycle is never refilled.
  always_comb begin : next_state
    valid_d    = valid_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    imm_d      = imm_q;
    dest_d     = dest_q;
`ifdef RS_OLDEST_FIRST_EN
    age_d      = age_q;
`endif
    alu_op_d   = OP_NONE;
    alu_a_d    = '0;
    alu_b_d    = '0;
    alu_imm_d  = '0;
    alu_dest_d = 3'd0;
    if (flush) begin
      valid_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i]) begin
          src1_d[i] = resolve(src1_q[i], alu_num, alu_value, mem_num, mem_value);
          src2_d[i] = resolve(src2_q[i], alu_num, alu_value, mem_num, mem_value);
`ifdef RS_OLDEST_FIRST_EN
          if (!(issue && sel_idx == IDX_W'(i)) && age_q[i] != 3'd7)
            age_d[i] = age_q[i] + 3'd1;
`endif
        end
      end
      if (issue) begin
        valid_d[sel_idx] = 1'b0;
        alu_op_d         = op_q[sel_idx];
        alu_a_d          = src1_q[sel_idx].val;
        alu_b_d          = src2_q[sel_idx].val;
        alu_imm_d        = imm_q[sel_idx];
        alu_dest_d       = dest_q[sel_idx];
      end
      if (dispatch) begin
        valid_d[free_idx] = 1'b1;
        op_d[free_idx]    = op_in;
        src1_d[free_idx]  = resolve({query1_in, value1_in}, alu_num, alu_value, mem_num, mem_value);
        src2_d[free_idx]  = resolve({query2_in, value2_in}, alu_num, alu_value, mem_num, mem_value);
        imm_d[free_idx]   = imm_in;
        dest_d[free_idx]  = target_in;
`ifdef RS_OLDEST_FIRST_EN
        age_d[free_idx]   = 3'd0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      alu_op_q   <= OP_NONE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_imm_q  <= '0;
      alu_dest_q <= 3'd0;
    end else begin
      valid_q    <= valid_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_imm_q  <= alu_imm_d;
      alu_dest_q <= alu_dest_d;
    end
  end

  // Payload is only meaningful while its valid bit is set, so it needs no reset.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    src1_q <= src1_d;
    src2_q <= src2_d;
    imm_q  <= imm_d;
    dest_q <= dest_d;
`ifdef RS_OLDEST_FIRST_EN
    age_q  <= age_d;
`endif
  end

  assign alu_op   = alu_op_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_imm  = alu_imm_q;
  assign alu_dest = alu_dest_q;
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenarios plus randomized traffic checked against an entry-list model.
// Honours RS_OLDEST_FIRST_EN the same way the design does.
module tb_reservation_station;
  localparam int DEPTH = 4;
  localparam logic [4:0] NOP = 5'b11111;
  localparam int AGE_MAX = 7;

  logic        clk = 1'b0;
  logic        rst, flush, alu_ready;
  logic [4:0]  op_in;
  logic [31:0] value1_in, value2_in, imm_in, alu_value, mem_value;
  logic [2:0]  query1_in, query2_in, target_in, alu_num, mem_num;
  logic        rs_full;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_imm;
  logic [2:0]  alu_dest;

  int checks = 0;
  int passes = 0;

  reservation_station #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .op_in(op_in),
    .value1_in(value1_in), .value2_in(value2_in),
    .query1_in(query1_in), .query2_in(query2_in),
    .imm_in(imm_in), .target_in(target_in),
    .alu_num(alu_num), .alu_value(alu_value),
    .mem_num(mem_num), .mem_value(mem_value),
    .alu_ready(alu_ready), .rs_full(rs_full),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_imm(alu_imm), .alu_dest(alu_dest)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [4:0]  op;
    logic [31:0] v1, v2, imm;
    logic [2:0]  q1, q2, dest;
    int          age;
  } ent_t;

  ent_t        m [DEPTH];
  logic [4:0]  e_op;
  logic [31:0] e_a, e_b, e_imm;
  logic [2:0]  e_dest;

  function automatic logic [34:0] bcast(input logic [2:0] q, input logic [31:0] v);
    if (q != 3'd0 && q == alu_num) return {3'd0, alu_value};
    if (q != 3'd0 && q == mem_num) return {3'd0, mem_value};
    return {q, v};
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < DEPTH; i++) if (!m[i].valid) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i].valid = 1'b0;
    e_op = NOP; e_dest = 3'd0; e_a = '0; e_b = '0; e_imm = '0;
  endtask

  // Advance model with the inputs presented for this edge, then step the clock.
  task automatic tick();
    int sel, slot;
    bit full;
    full = model_full();
    slot = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].valid) slot = i;
    sel = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].valid && m[i].q1 == 3'd0 && m[i].q2 == 3'd0) begin
`ifdef RS_OLDEST_FIRST_EN
        if (sel < 0 || m[i].age > m[sel].age) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    end
    if (!alu_ready) sel = -1;
    e_op = NOP; e_dest = 3'd0; e_a = '0; e_b = '0; e_imm = '0;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m[i].valid = 1'b0;
    end else begin
      if (sel >= 0) begin
        e_op = m[sel].op; e_a = m[sel].v1; e_b = m[sel].v2;
        e_imm = m[sel].imm; e_dest = m[sel].dest;
        m[sel].valid = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (m[i].valid) begin
          {m[i].q1, m[i].v1} = bcast(m[i].q1, m[i].v1);
          {m[i].q2, m[i].v2} = bcast(m[i].q2, m[i].v2);
          if (m[i].age < AGE_MAX) m[i].age++;
        end
      end
      if (op_in != NOP && !full) begin
        m[slot].valid = 1'b1;
        m[slot].op    = op_in;
        {m[slot].q1, m[slot].v1} = bcast(query1_in, value1_in);
        {m[slot].q2, m[slot].v2} = bcast(query2_in, value2_in);
        m[slot].imm   = imm_in;
        m[slot].dest  = target_in;
        m[slot].age   = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    flush = 1'b0; op_in = NOP; query1_in = 3'd0; query2_in = 3'd0;
    alu_num = 3'd0; mem_num = 3'd0; target_in = 3'd1;
    value1_in = $urandom; value2_in = $urandom; imm_in = $urandom;
    alu_value = $urandom; mem_value = $urandom;
  endtask

  task automatic drain();
    quiet_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic dispatch(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [2:0] q1, input logic [2:0] q2, input logic [2:0] tgt);
    op_in = op; value1_in = v1; value2_in = v2; query1_in = q1; query2_in = q2;
    target_in = tgt; imm_in = {27'd0, op};
    tick();
    op_in = NOP; query1_in = 3'd0; query2_in = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    alu_ready = 1'b1;
    quiet_inputs();
    model_reset();
    #12;
    checks++;
    if ({alu_op, alu_dest} !== {NOP, 3'd0}) begin
      $display("[TB] FAIL reset_bundle: got op=%b dest=%0d expected op=11111 dest=0", alu_op, alu_dest);
    end else passes++;
    checks++;
    if ({alu_a, alu_b, alu_imm, rs_full} !== 97'd0) begin
      $display("[TB] FAIL reset_data: got a=%h b=%h imm=%h full=%b expected all zero", alu_a, alu_b, alu_imm, rs_full);
    end else passes++;
    #8 rst = 1'b1;
    tick();
  endtask

  task automatic test_add();
    alu_ready = 1'b1;
    dispatch(5'b00000, 32'd5, 32'd7, 3'd0, 3'd0, 3'd3);
    checks++;
    if (alu_op !== NOP) $display("[TB] FAIL add_not_early: got op=%b expected 11111", alu_op);
    else passes++;
    tick();
    checks++;
    if ({alu_op, alu_a, alu_b, alu_dest} !== {5'b00000, 32'd5, 32'd7, 3'd3})
      $display("[TB] FAIL add_issue: got op=%b a=%0d b=%0d dest=%0d expected 00000/5/7/3", alu_op, alu_a, alu_b, alu_dest);
    else passes++;
    tick();
    checks++;
    if ({alu_op, alu_dest} !== {NOP, 3'd0}) $display("[TB] FAIL add_idle: got op=%b dest=%0d expected idle", alu_op, alu_dest);
    else passes++;
  endtask

  task automatic test_wakeup();
    alu_ready = 1'b1;
    dispatch(5'd1, 32'hDEAD, 32'd9, 3'd2, 3'd0, 3'd4);
    tick();
    alu_num = 3'd2; alu_value = 32'h10;
    tick();
    alu_num = 3'd0;
    checks++;
    if (alu_op !== NOP) $display("[TB] FAIL wake_not_early: got op=%b expected 11111", alu_op);
    else passes++;
    tick();
    checks++;
    if ({alu_op, alu_a, alu_b, alu_dest} !== {5'd1, 32'h10, 32'd9, 3'd4})
      $display("[TB] FAIL wake_issue: got op=%b a=%h b=%0d dest=%0d expected 00001/10/9/4", alu_op, alu_a, alu_b, alu_dest);
    else passes++;
    // Both buses carrying the same tag: ALU value must be taken.
    dispatch(5'd2, 32'h0, 32'd1, 3'd3, 3'd0, 3'd6);
    alu_num = 3'd3; alu_value = 32'hAAAA; mem_num = 3'd3; mem_value = 32'hBBBB;
    tick();
    alu_num = 3'd0; mem_num = 3'd0;
    tick();
    checks++;
    if ({alu_a, alu_dest} !== {32'hAAAA, 3'd6})
      $display("[TB] FAIL same_tag_alu_wins: got a=%h dest=%0d expected a=aaaa dest=6", alu_a, alu_dest);
    else passes++;
  endtask

  task automatic test_forward();
    alu_ready = 1'b1;
    mem_num = 3'd5; mem_value = 32'hABCD;
    dispatch(5'd2, 32'd1, 32'd0, 3'd0, 3'd5, 3'd5);
    mem_num = 3'd0;
    tick();
    checks++;
    if ({alu_op, alu_b, alu_dest} !== {5'd2, 32'hABCD, 3'd5})
      $display("[TB] FAIL forward_issue: got op=%b b=%h dest=%0d expected 00010/abcd/5", alu_op, alu_b, alu_dest);
    else passes++;
  endtask

  task automatic test_full();
    alu_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) dispatch(5'd3, 32'd0, 32'(i), 3'd6, 3'd0, 3'(i + 1));
    checks++;
    if (rs_full !== 1'b1) $display("[TB] FAIL full_set: got %b expected 1", rs_full);
    else passes++;
    dispatch(5'd4, 32'd1, 32'd1, 3'd0, 3'd0, 3'd7);
    checks++;
    if ({rs_full, alu_op} !== {1'b1, NOP}) $display("[TB] FAIL full_drop: got full=%b op=%b expected 1/11111", rs_full, alu_op);
    else passes++;
    alu_num = 3'd6; alu_value = 32'h66;
    tick();
    alu_num = 3'd0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      checks++;
      if ({alu_dest, alu_a, alu_b} !== {3'(i + 1), 32'h66, 32'(i)})
        $display("[TB] FAIL full_drain: got dest=%0d a=%h b=%0d expected dest=%0d a=66 b=%0d", alu_dest, alu_a, alu_b, i + 1, i);
      else passes++;
    end
    tick();
    checks++;
    if ({rs_full, alu_op, alu_dest} !== {1'b0, NOP, 3'd0})
      $display("[TB] FAIL full_dropped_gone: got full=%b op=%b dest=%0d expected empty and idle", rs_full, alu_op, alu_dest);
    else passes++;
  endtask

  task automatic test_priority();
    logic [2:0] first_dest, second_dest;
`ifdef RS_OLDEST_FIRST_EN
    first_dest = 3'd3; second_dest = 3'd4;
`else
    first_dest = 3'd4; second_dest = 3'd3;
`endif
    alu_ready = 1'b0;
    dispatch(5'd5, 32'd1, 32'd1, 3'd0, 3'd0, 3'd1);
    dispatch(5'd5, 32'd2, 32'd2, 3'd6, 3'd0, 3'd2);
    dispatch(5'd5, 32'd3, 32'd3, 3'd0, 3'd0, 3'd3);
    alu_ready = 1'b1;
    tick();
    checks++;
    if (alu_dest !== 3'd1) $display("[TB] FAIL prio_first: got dest=%0d expected 1", alu_dest);
    else passes++;
    alu_ready = 1'b0;
    dispatch(5'd5, 32'd4, 32'd4, 3'd0, 3'd0, 3'd4);
    alu_ready = 1'b1;
    tick();
    checks++;
    if (alu_dest !== first_dest) $display("[TB] FAIL prio_pick: got dest=%0d expected %0d", alu_dest, first_dest);
    else passes++;
    tick();
    checks++;
    if (alu_dest !== second_dest) $display("[TB] FAIL prio_second: got dest=%0d expected %0d", alu_dest, second_dest);
    else passes++;
    alu_num = 3'd6; alu_value = 32'h77;
    tick();
    alu_num = 3'd0;
    tick();
    checks++;
    if ({alu_dest, alu_a} !== {3'd2, 32'h77}) $display("[TB] FAIL prio_woken: got dest=%0d a=%h expected 2/77", alu_dest, alu_a);
    else passes++;
  endtask

  task automatic test_flush();
    alu_ready = 1'b0;
    dispatch(5'd6, 32'd0, 32'd0, 3'd6, 3'd0, 3'd1);
    dispatch(5'd6, 32'd0, 32'd0, 3'd6, 3'd0, 3'd2);
    dispatch(5'd6, 32'd0, 32'd0, 3'd0, 3'd0, 3'd3);
    flush = 1'b1; alu_ready = 1'b1;
    dispatch(5'd7, 32'd1, 32'd1, 3'd0, 3'd0, 3'd5);
    flush = 1'b0;
    checks++;
    if ({rs_full, alu_op, alu_dest} !== {1'b0, NOP, 3'd0})
      $display("[TB] FAIL flush_clear: got full=%b op=%b dest=%0d expected 0/11111/0", rs_full, alu_op, alu_dest);
    else passes++;
    alu_num = 3'd6; alu_value = 32'h1;
    for (int i = 0; i < 3; i++) begin
      tick();
      alu_num = 3'd0;
      checks++;
      if ({alu_op, alu_dest} !== {NOP, 3'd0}) $display("[TB] FAIL flush_no_issue: got op=%b dest=%0d expected idle", alu_op, alu_dest);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    alu_ready = 1'b0;
    dispatch(5'd8, 32'd1, 32'd1, 3'd0, 3'd0, 3'd1);
    dispatch(5'd8, 32'd2, 32'd2, 3'd0, 3'd0, 3'd2);
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({rs_full, alu_op, alu_dest} !== {1'b0, NOP, 3'd0})
      $display("[TB] FAIL reset_mid_async: got full=%b op=%b dest=%0d expected 0/11111/0", rs_full, alu_op, alu_dest);
    else passes++;
    #2 rst = 1'b1;
    alu_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (alu_op !== NOP) $display("[TB] FAIL reset_mid_discard: got op=%b expected 11111", alu_op);
      else passes++;
    end
    alu_ready = 1'b0;
    dispatch(5'd9, 32'd5, 32'd5, 3'd0, 3'd0, 3'd5);
    dispatch(5'd9, 32'd6, 32'd6, 3'd0, 3'd0, 3'd6);
    alu_ready = 1'b1;
    tick();
    checks++;
    if (alu_dest !== 3'd5) $display("[TB] FAIL reset_first_slot: got dest=%0d expected 5", alu_dest);
    else passes++;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      flush     = ($urandom_range(0, 49) == 0);
      op_in     = ($urandom_range(0, 3) == 0) ? NOP : 5'($urandom_range(0, 30));
      value1_in = $urandom; value2_in = $urandom; imm_in = $urandom;
      query1_in = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      query2_in = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      target_in = 3'($urandom_range(1, 7));
      alu_num   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      mem_num   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      alu_value = $urandom; mem_value = $urandom;
      alu_ready = ($urandom_range(0, 3) != 0);
      checks++;
      if (rs_full !== model_full()) $display("[TB] FAIL rand_full: cycle %0d got %b expected %b", n, rs_full, model_full());
      else passes++;
      tick();
      checks++;
      if ({alu_op, alu_dest} !== {e_op, e_dest} ||
          (e_op != NOP && {alu_a, alu_b, alu_imm} !== {e_a, e_b, e_imm}))
        $display("[TB] FAIL rand_issue: cycle %0d got op=%b a=%h b=%h imm=%h dest=%0d expected op=%b a=%h b=%h imm=%h dest=%0d",
                 n, alu_op, alu_a, alu_b, alu_imm, alu_dest, e_op, e_a, e_b, e_imm, e_dest);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    drain();
    test_wakeup();
    drain();
    test_forward();
    drain();
    test_full();
    drain();
    test_priority();
    drain();
    test_flush();
    drain();
    test_reset_mid();
    drain();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
